// File: rtl/mult_pkg.sv
// Shared types and constants for the signed add-shift multiplier sequencer.
// Contents:
//   state_e    - controller state encoding
//   MULT_WIDTH - default multiplier width (iteration count)
//   cnt_width  - width of an iteration counter able to hold 0..w-1
package mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_EXEC  = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  localparam int MULT_WIDTH = 8;

  // Never returns less than 1 so the counter vector is always legal.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_seq_control.sv
// Sequencing controller for the signed add-shift multiplier datapath
// (X:A accumulator, B multiplier register, adder and subtracter).
// A Run rising edge clears X:A, then runs WIDTH iterations of
// {add/subtract decision, arithmetic shift}. The last iteration subtracts
// so that the multiplier MSB carries negative weight.
// Ports:
//   Clk          in  system clock, rising edge
//   Reset_n      in  asynchronous active-low reset
//   Run          in  multiply request (level); starts on its rising edge
//   ClearA_LoadB in  clear X:A and load B; honoured in IDLE only
//   M            in  current LSB of B
//   Clr_Ld       out clear X:A, load B from switches
//   Clr_XA       out clear X and A only
//   Add_En       out load X:A with adder result
//   Sub_En       out load X:A with subtracter result
//   Shift_En     out arithmetic right shift of X:A:B
//   Busy         out operation in progress
//   Done         out result in X:A:B valid
// WIDTH must be >= 2.
module mult_seq_control
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clr_XA,
  output logic Add_En,
  output logic Sub_En,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_run_q;
  logic          w_start;
  logic          w_last;

  assign w_start = Run & ~r_run_q;
  assign w_last  = (r_cnt == LAST);

  // State, iteration counter and Run edge detector.
  // r_run_q resets high so a Run held through reset cannot start an operation.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_run_q <= 1'b1;
    end else begin
      r_run_q <= Run;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_CLR;
          end
        end
        S_CLR: begin
          r_cnt   <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last) begin
            r_state <= S_HOLD;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            r_state <= S_EXEC;
          end
        end
        // Stay until Run is released: no automatic second multiply.
        S_HOLD: begin
          if (!Run) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output decode: state-only except Clr_Ld (follows the request in IDLE)
  // and Add_En/Sub_En (qualified by M during EXEC).
  always_comb begin
    Clr_Ld   = 1'b0;
    Clr_XA   = 1'b0;
    Add_En   = 1'b0;
    Sub_En   = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A start on the same cycle wins over a load request; Reset_n gating
        // keeps every output low while reset is held.
        Clr_Ld = ClearA_LoadB & ~w_start & Reset_n;
      end
      S_CLR: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
      end
      S_EXEC: begin
        Busy   = 1'b1;
        Add_En = M & ~w_last;
        Sub_En = M & w_last;
      end
      S_SHIFT: begin
        Shift_En = 1'b1;
        Busy     = 1'b1;
      end
      S_HOLD: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_seq_control.sv
// Self-checking bench for mult_seq_control (WIDTH = 8).
// The reference model tracks only "cycles since the start edge" and derives
// the expected outputs from that offset; a small B register model drives M.
module tb_mult_seq_control;

  localparam int W      = 8;
  localparam int HOLD_T = 2 * W + 2;

  logic Clk = 1'b0;
  logic Reset_n, Run, ClearA_LoadB, M;
  logic Clr_Ld, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done;
  logic [7:0] sw = 8'h00;
  logic [7:0] b_r = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  mult_seq_control #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_Ld(Clr_Ld), .Clr_XA(Clr_XA), .Add_En(Add_En), .Sub_En(Sub_En),
    .Shift_En(Shift_En), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // B register stand-in: loads on Clr_Ld, shifts right on Shift_En.
  assign M = b_r[0];
  always @(posedge Clk) begin
    if (Clr_Ld) b_r <= sw;
    else if (Shift_En) b_r <= {1'b0, b_r[7:1]};
  end

  // Reference model: m_t = 0 idle, 1 clear, 2..2W+1 iterations, HOLD_T done.
  int m_t   = 0;
  bit m_runq = 1'b1;
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_t    <= 0;
      m_runq <= 1'b1;
    end else begin
      m_runq <= Run;
      if (m_t == 0) begin
        if (Run && !m_runq) m_t <= 1;
      end else if (m_t < HOLD_T) begin
        m_t <= m_t + 1;
      end else if (!Run) begin
        m_t <= 0;
      end
    end
  end

  // Pulse recorders (written only from the main initial process).
  int cyc = 0, c0 = 0, clr_cnt = 0, ld_cnt = 0, sh_cnt = 0, done_cnt = 0, done_off = -1;
  int add_q[$];
  int sub_q[$];

  function automatic logic [6:0] expected();
    logic [6:0] e;
    int it;
    e = 7'b0;
    if (m_t == 0) begin
      e[6] = ClearA_LoadB & ~(Run & ~m_runq) & Reset_n;
    end else if (m_t == 1) begin
      e[5] = 1'b1; e[1] = 1'b1;
    end else if (m_t <= 2 * W + 1) begin
      e[1] = 1'b1;
      if ((m_t % 2) == 0) begin
        it   = (m_t - 2) / 2;
        e[4] = M & (it != W - 1);
        e[3] = M & (it == W - 1);
      end else begin
        e[2] = 1'b1;
      end
    end else begin
      e[0] = 1'b1;
    end
    return e;
  endfunction

  task automatic check_cycle();
    logic [6:0] got, exp;
    got = {Clr_Ld, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done};
    exp = expected();
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle %0d outputs{ld,xa,add,sub,sh,busy,done} got=%b exp=%b (m_t=%0d)",
               cyc, got, exp, m_t);
    end
    if (Clr_XA) begin clr_cnt++; c0 = cyc; end
    if (Clr_Ld) ld_cnt++;
    if (Add_En) add_q.push_back(cyc - c0);
    if (Sub_En) sub_q.push_back(cyc - c0);
    if (Shift_En) sh_cnt++;
    if (Done) begin
      if (done_cnt == 0) done_off = cyc - c0;
      done_cnt++;
    end
    cyc++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      check_cycle();
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic rec_clear();
    clr_cnt = 0; ld_cnt = 0; sh_cnt = 0; done_cnt = 0; done_off = -1;
    add_q.delete(); sub_q.delete();
  endtask

  task automatic wait_model(input int target);
    for (int i = 0; i < 40 && m_t != target; i++) tick(1);
    chk("wait_model_timeout", m_t, target);
  endtask

  initial begin
    Reset_n = 1'b0; Run = 1'b1; ClearA_LoadB = 1'b0;
    #2;
    // Run held through reset must not start anything.
    tick(3);
    Reset_n = 1'b1;
    rec_clear();
    tick(20);
    chk("held_run_busy", int'(Busy), 0);
    chk("held_run_clr", clr_cnt, 0);
    Run = 1'b0;
    tick(2);

    // Load B = 1000_0101 for exactly 3 cycles.
    rec_clear();
    sw = 8'b1000_0101; ClearA_LoadB = 1'b1;
    tick(3);
    ClearA_LoadB = 1'b0;
    tick(2);
    chk("load_pulses", ld_cnt, 3);

    // Full multiply; load request pulsed while busy must be ignored.
    rec_clear();
    Run = 1'b1;
    tick(4);
    ClearA_LoadB = 1'b1;
    tick(2);
    ClearA_LoadB = 1'b0;
    tick(16);
    chk("mul_clr_xa", clr_cnt, 1);
    chk("mul_ld_busy", ld_cnt, 0);
    chk("mul_add_n", add_q.size(), 2);
    chk("mul_add0_off", add_q[0], 1);
    chk("mul_add1_off", add_q[1], 5);
    chk("mul_sub_n", sub_q.size(), 1);
    chk("mul_sub0_off", sub_q[0], 15);
    chk("mul_shifts", sh_cnt, 8);
    chk("mul_done_off", done_off, 17);

    // Hold with Run held: Done stays, no restart.
    tick(30);
    chk("hold_done", int'(Done), 1);
    chk("hold_no_restart", clr_cnt, 1);
    Run = 1'b0;
    tick(1);
    chk("release_done", int'(Done), 0);
    chk("release_busy", int'(Busy), 0);
    Run = 1'b1;
    tick(2);
    chk("restart_clr", clr_cnt, 2);
    tick(20);
    Run = 1'b0;
    tick(2);

    // Run dropped at EXEC(3): completes, Done for one cycle.
    sw = 8'b0110_1011; ClearA_LoadB = 1'b1;
    tick(1);
    ClearA_LoadB = 1'b0;
    tick(1);
    rec_clear();
    Run = 1'b1;
    wait_model(2 + 2 * 3);
    Run = 1'b0;
    tick(25);
    chk("drop_shifts", sh_cnt, 8);
    chk("drop_done_cycles", done_cnt, 1);
    chk("drop_idle_busy", int'(Busy), 0);

    // Reset during SHIFT(4) with Run held.
    rec_clear();
    Run = 1'b1;
    wait_model(2 + 2 * 4 + 1);
    chk("pre_reset_shift", int'(Shift_En), 1);
    Reset_n = 1'b0;
    #1;
    chk("reset_outputs", int'({Clr_Ld, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done}), 0);
    tick(2);
    Reset_n = 1'b1;
    rec_clear();
    tick(10);
    chk("post_reset_no_restart", clr_cnt, 0);
    Run = 1'b0;
    tick(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) Run = ~Run;
      ClearA_LoadB = ($urandom_range(0, 9) == 0);
      sw = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        Reset_n = 1'b0;
        tick(1);
        Reset_n = 1'b1;
      end
      tick(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
